// File: rtl/regfile_pkg.sv
// Shared constants for the 8-bit register file with a buffered read port.
//   WIDTH          : entry width in bits
//   RESET_VAL      : value loaded into entries and read data on reset
//   SET_VAL        : value loaded into every entry on set
//   DEFAULT_DEPTH  : default number of entries
//   DEFAULT_ADDR_W : default address width, log2(DEFAULT_DEPTH)
package regfile_pkg;

  localparam int unsigned WIDTH          = 8;
  localparam logic [7:0]  RESET_VAL      = 8'h00;
  localparam logic [7:0]  SET_VAL        = 8'hFF;
  localparam int unsigned DEFAULT_DEPTH  = 8;
  localparam int unsigned DEFAULT_ADDR_W = 3;

endpackage

// File: rtl/rf_entry8.sv
// Single 8-bit storage entry.
// Priority on each rising edge: rst > set > we; the entry holds otherwise.
//   clk   : clock
//   rst   : synchronous active-high reset to RESET_VAL
//   set   : synchronous active-high preset to SET_VAL
//   we    : write enable for wdata
//   wdata : write data
//   q     : stored value
module rf_entry8
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_d;
  logic [WIDTH-1:0] val_q;

  always_comb begin
    val_d = val_q;
    if (rst) begin
      val_d = RESET_VAL;
    end else if (set) begin
      val_d = SET_VAL;
    end else if (we) begin
      val_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    val_q <= val_d;
  end

  assign q = val_q;

endmodule

// File: rtl/regfile8_rd.sv
// Register file of DEPTH 8-bit entries with an independent write port and a
// valid/ready read port that answers one cycle after request acceptance
// through a 1-deep response buffer.
//   clk, rst       : clock, synchronous active-high reset
//   set            : preset all entries to SET_VAL
//   we/waddr/wdata : write port (never stalls)
//   rd_req_valid/rd_req_ready/rd_addr   : read request handshake
//   rd_resp_valid/rd_resp_ready/rd_data : read response handshake
module regfile8_rd
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0] entry_we;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign entry_we[i] = we && (waddr == ADDR_W'(i));

    rf_entry8 u_entry (
      .clk   (clk),
      .rst   (rst),
      .set   (set),
      .we    (entry_we[i]),
      .wdata (wdata),
      .q     (entry_q[i])
    );
  end

  logic             resp_valid_q;
  logic             resp_valid_d;
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_next_val;
  logic             req_accept;

  // The buffer can take a new request when empty or when its current
  // response retires on this same edge; reset blocks acceptance.
  assign rd_req_ready = !rst && (!resp_valid_q || rd_resp_ready);
  assign req_accept   = rd_req_valid && rd_req_ready;

  // Write-first bypass: return the entry as it will look after this edge.
  always_comb begin
    rd_next_val = entry_q[rd_addr];
    if (set) begin
      rd_next_val = SET_VAL;
    end else if (we && (waddr == rd_addr)) begin
      rd_next_val = wdata;
    end
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    rd_data_d    = rd_data_q;
    if (rst) begin
      resp_valid_d = 1'b0;
      rd_data_d    = RESET_VAL;
    end else if (req_accept) begin
      resp_valid_d = 1'b1;
      rd_data_d    = rd_next_val;
    end else if (resp_valid_q && rd_resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    resp_valid_q <= resp_valid_d;
    rd_data_q    <= rd_data_d;
  end

  assign rd_resp_valid = resp_valid_q;
  assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_regfile8_rd.sv
module tb_regfile8_rd;

  logic       clk = 1'b0;
  logic       rst, set, we, rd_req_valid, rd_resp_ready;
  logic [2:0] waddr, rd_addr;
  logic [7:0] wdata;
  logic       rd_req_ready, rd_resp_valid;
  logic [7:0] rd_data;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: contents array, buffered response and in-flight queue.
  logic [7:0] mem [8];
  bit         m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic [7:0] pend_q [$];

  always #5 clk = ~clk;

  regfile8_rd #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .set           (set),
    .we            (we),
    .waddr         (waddr),
    .wdata         (wdata),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_addr       (rd_addr),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_ready (rd_resp_ready),
    .rd_data       (rd_data)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational ready and any
  // retiring response, then advance the model across the edge and check.
  task automatic step(input bit i_rst, input bit i_set, input bit i_we,
                      input int unsigned i_waddr, input logic [7:0] i_wdata,
                      input bit i_rv, input int unsigned i_raddr, input bit i_rr);
    bit exp_ready;
    bit acc;
    logic [7:0] popped;
    rst = i_rst; set = i_set; we = i_we;
    waddr = 3'(i_waddr); wdata = i_wdata;
    rd_req_valid = i_rv; rd_addr = 3'(i_raddr); rd_resp_ready = i_rr;
    #1;
    exp_ready = !i_rst && (!m_valid || i_rr);
    chk("rd_req_ready", {7'b0, rd_req_ready}, {7'b0, exp_ready});
    if (!i_rst && m_valid && i_rr) begin
      if (pend_q.size() == 0) begin
        chk("resp_without_request", 8'h01, 8'h00);
      end else begin
        popped = pend_q.pop_front();
        chk("resp_order_data", rd_data, popped);
      end
    end
    acc = i_rv && exp_ready;
    @(posedge clk);
    if (i_rst) begin
      foreach (mem[k]) mem[k] = 8'h00;
      m_valid = 1'b0;
      m_data  = 8'h00;
      pend_q.delete();
    end else begin
      if (i_set) foreach (mem[k]) mem[k] = 8'hFF;
      else if (i_we) mem[i_waddr] = i_wdata;
      if (acc) begin
        m_valid = 1'b1;
        m_data  = mem[i_raddr];
        pend_q.push_back(m_data);
      end else if (m_valid && i_rr) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("rd_resp_valid", {7'b0, rd_resp_valid}, {7'b0, m_valid});
    chk("rd_data", rd_data, m_data);
  endtask

  task automatic read1(input int unsigned a);
    step(0, 0, 0, 0, 8'h00, 1, a, 1);
  endtask

  initial begin
    rst = 1'b0; set = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    rd_req_valid = 1'b0; rd_addr = '0; rd_resp_ready = 1'b0;
    foreach (mem[k]) mem[k] = 8'h00;
    @(negedge clk);

    // Reset and read back all entries.
    step(1, 0, 0, 0, 8'h00, 0, 0, 1);
    chk("reset_valid", {7'b0, rd_resp_valid}, 8'h00);
    chk("reset_data", rd_data, 8'h00);
    for (int a = 0; a < 8; a++) begin
      read1(a);
      chk("reset_entry", rd_data, 8'h00);
    end

    // Write then read; a write with we=0 must not change the entry.
    step(0, 0, 1, 3, 8'hAA, 0, 0, 1);
    read1(3);
    chk("write_aa_valid", {7'b0, rd_resp_valid}, 8'h01);
    chk("write_aa_data", rd_data, 8'hAA);
    step(0, 0, 0, 3, 8'h55, 1, 3, 1);
    chk("we0_hold", rd_data, 8'hAA);

    // Same-edge bypass for write and for set.
    step(0, 0, 1, 5, 8'h3C, 1, 5, 1);
    chk("bypass_write", rd_data, 8'h3C);
    step(0, 1, 0, 0, 8'h00, 1, 0, 1);
    chk("bypass_set", rd_data, 8'hFF);

    // Backpressure: response held while its entry is rewritten.
    step(0, 0, 1, 2, 8'h77, 0, 0, 1);
    read1(2);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 1, 2, 8'h11, 1, 2, 0);
      chk("stall_data", rd_data, 8'h77);
      chk("stall_ready", {7'b0, rd_req_ready}, 8'h00);
    end
    step(0, 0, 0, 0, 8'h00, 1, 2, 1);
    chk("release_reload_valid", {7'b0, rd_resp_valid}, 8'h01);
    chk("release_reload_data", rd_data, 8'h11);

    // Reset while stalled, then rst together with set.
    step(0, 0, 0, 0, 8'h00, 0, 0, 0);
    step(1, 0, 0, 0, 8'h00, 0, 0, 0);
    chk("rst_stall_valid", {7'b0, rd_resp_valid}, 8'h00);
    read1(3);
    chk("rst_stall_entry", rd_data, 8'h00);
    step(1, 1, 1, 4, 8'h99, 1, 4, 1);
    for (int a = 0; a < 8; a++) begin
      read1(a);
      chk("rst_set_entry", rd_data, 8'h00);
    end

    // Random traffic against the model.
    for (int c = 0; c < 200; c++) begin
      step(($urandom_range(49) == 0), ($urandom_range(19) == 0),
           ($urandom_range(1) == 1), $urandom_range(7), 8'($urandom),
           ($urandom_range(3) != 0), $urandom_range(7), ($urandom_range(3) != 0));
    end

    // Drain so every accepted request has produced exactly one response.
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 8'h00, 0, 0, 1);
    chk("all_responses_retired", 8'(pend_q.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
